decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PC_W, default 32, width of the pc tag carried with each instruction.
REQ-003 SHALL use one clock; reset is asynchronous and active-high: port clk, input, 1, rising-edge clock.
REQ-004 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide flush, input, 1, synchronous discard of all held instructions.
REQ-006 SHALL provide in_valid, input, 1; in_ir, input, 32; in_pc, input, PC_W; in_ready, output, 1: fetch-side handshake.
REQ-007 SHALL provide out_valid, output, 1; out_ready, input, 1; out_ir, output, 32; out_pc, output, PC_W: issue-side handshake.
REQ-008 SHALL provide registered controls: regWrite 1, memWrite 1, memRead 1, alu_fun 4, alu_srcA 1, alu_srcB 2, rf_wr_sel 1, opcode 7, illegal 1, mul_en 1, mul_op 3.
REQ-009 SHALL provide count, output, $clog2(DEPTH)+1, FIFO occupancy excluding the output register.

Function
REQ-010 SHALL accept an instruction on any clk edge where in_valid && in_ready; in_ready = (count < DEPTH), with no pass-through when full, even if popping.
REQ-011 SHALL load the output register from the FIFO head, decoded, on an edge where the FIFO is non-empty and (!out_valid || out_ready); a simultaneous push and pop leaves count unchanged.
REQ-012 SHALL give two-edge latency into an empty queue: accepted at edge k, out_valid high after edge k+1.
REQ-013 SHALL hold every output register stable while out_valid && !out_ready.
REQ-014 SHALL, on flush, clear count, read/write pointers and out_valid at that edge; flush has priority over a same-edge push and pop.
REQ-015 SHALL decode alu_fun as ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI 1001, SRA 1101.
REQ-016 SHALL use ir[30] to select SRA over SRL for OP_IMM and OP_RG3, and SUB over ADD for OP_RG3 only.
REQ-017 SHALL drive alu_srcA=1 for AUIPC, JAL, JALR, BRANCH; alu_srcB=10 for JAL/JALR, 01 for OP_RG3/SYS, else 00.
REQ-018 SHALL assert regWrite for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP_RG3, and SYS with func3=001; memWrite only for STORE; memRead and rf_wr_sel only for LOAD.
REQ-019 SHALL flag an unrecognised opcode as illegal=1 with regWrite, memWrite, memRead, alu_fun, alu_srcA, alu_srcB, rf_wr_sel all zero.
REQ-020 SHALL compute count wrap-free; pointers wrap modulo DEPTH.

Reset
REQ-021 SHALL, on rst high, immediately clear pointers, count, out_valid and all control outputs to 0, with in_ready=1 after release.
REQ-022 SHALL discard in-flight instructions on reset mid-operation; no stale entry reappears after release.

Configuration
REQ-023 SHALL, with DECODE_QUEUE_MEXT_EN defined, decode OP_RG3 with ir[31:25]=0000001 as mul_en=1, mul_op=func3, regWrite=1, alu_fun=0000.
REQ-024 SHALL, without DECODE_QUEUE_MEXT_EN, tie mul_en and mul_op to 0 and flag those encodings illegal=1.

Structure
REQ-025 SHALL place opcode_t, alu_fun constants and the control-bundle struct in package starfish_pkg.
REQ-026 SHALL implement decode as combinational sub-module decode_ctrl (ir in, bundle out) feeding the output register.

Verification
REQ-027 ADDI x1,x0,5 (0x00500093) into empty queue -> after 2 edges out_valid=1, alu_fun=0000, alu_srcB=00, regWrite=1, illegal=0.
REQ-028 SUB x1,x1,x2 (0x402080B3) then SRAI x1,x1,3 (0x4030D093) -> alu_fun 1000/srcB 01, then 1101/srcB 00, in order.
REQ-029 out_ready=0, DEPTH=4, continuous in_valid -> 5 instructions accepted (4 FIFO + output register), count=4, in_ready=0; one out_ready pulse -> in_ready=1 next cycle.
REQ-030 Queue holding 3 entries, flush with in_valid=1 on the same edge -> count=0, out_valid=0, pushed instruction dropped.
REQ-031 Opcode 1111111 (0x0000007F) -> illegal=1, all write enables 0; MUL 0x022080B3 -> mul_en=1, mul_op=000 with DECODE_QUEUE_MEXT_EN, illegal=1 without.
REQ-032 rst asserted mid-stream with 2 entries queued -> outputs 0 immediately; after release the first new instruction is the first output.

Source files
------------

// File: rtl/starfish_pkg.sv
// Shared decode types for the decode queue: RV32 opcode encodings, ALU
// function codes and the packed control bundle carried in the output register.
package starfish_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_RG3    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // funct7 value that marks the M-extension multiply/divide group
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] alu_fun;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       rf_wr_sel;
    logic [6:0] opcode;
    logic       illegal;
    logic       mul_en;
    logic [2:0] mul_op;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32 control decoder: instruction word in, control bundle out.
// Build option: DECODE_QUEUE_MEXT_EN enables M-extension (mul_en/mul_op);
// without it those encodings are reported illegal.
module decode_ctrl
  import starfish_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl
);

  logic [2:0] func3;
  logic       alt;
  logic       is_mext;
  logic       unused_ir;

  assign func3     = ir[14:12];
  assign alt       = ir[30];
  assign is_mext   = (ir[31:25] == F7_MULDIV);
  // register indices and immediates do not affect control
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // decode opcode/funct fields into the control bundle
  always_comb begin
    ctrl        = '0;
    ctrl.opcode = ir[6:0];
    case (ir[6:0])
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_fun   = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      OP_BRANCH: ctrl.alu_src_a = 1'b1;
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.rf_wr_sel = 1'b1;
      end
      OP_STORE: ctrl.mem_write = 1'b1;
      OP_IMM: begin
        // ir[30] only distinguishes SRAI from SRLI; ADDI has no SUB form
        ctrl.reg_write = 1'b1;
        ctrl.alu_fun   = {(func3 == 3'b101) && alt, func3};
      end
      OP_RG3: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_fun   = {((func3 == 3'b000) || (func3 == 3'b101)) && alt, func3};
        if (is_mext) begin
`ifdef DECODE_QUEUE_MEXT_EN
          ctrl.alu_fun = ALU_ADD;
          ctrl.mul_en  = 1'b1;
          ctrl.mul_op  = func3;
`else
          ctrl         = '0;
          ctrl.opcode  = ir[6:0];
          ctrl.illegal = 1'b1;
`endif
        end
      end
      OP_SYS: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.reg_write = (func3 == 3'b001);
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Instruction FIFO followed by a registered decode stage. The FIFO holds up to
// DEPTH raw instructions; the output register holds one decoded instruction.
// Build option: DECODE_QUEUE_MEXT_EN (see decode_ctrl).
module decode_queue
  import starfish_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_ir,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_ir,
  output logic [PC_W-1:0]        out_pc,
  output logic                   regWrite,
  output logic                   memWrite,
  output logic                   memRead,
  output logic [3:0]             alu_fun,
  output logic                   alu_srcA,
  output logic [1:0]             alu_srcB,
  output logic                   rf_wr_sel,
  output logic [6:0]             opcode,
  output logic                   illegal,
  output logic                   mul_en,
  output logic [2:0]             mul_op,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]     ir_mem_q [DEPTH];
  logic [31:0]     ir_mem_d [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_ir_q, out_ir_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  ctrl_t           ctrl_q, ctrl_d, head_ctrl;
  logic [31:0]     head_ir;
  logic            push, pop;

  // full FIFO refuses input even if the head is leaving this edge
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready) && !flush;
  assign head_ir  = ir_mem_q[rd_ptr_q];

  decode_ctrl u_decode (
    .ir   (head_ir),
    .ctrl (head_ctrl)
  );

  // storage write for an accepted instruction
  always_comb begin
    ir_mem_d = ir_mem_q;
    pc_mem_d = pc_mem_q;
    if (push) begin
      ir_mem_d[wr_ptr_q] = in_ir;
      pc_mem_d[wr_ptr_q] = in_pc;
    end
  end

  // storage is not reset; validity comes from count and pointers
  always_ff @(posedge clk) begin
    ir_mem_q <= ir_mem_d;
    pc_mem_q <= pc_mem_d;
  end

  // next-state for pointers, occupancy and the output register
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_ir_d    = out_ir_q;
    out_pc_d    = out_pc_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (pop) begin
        out_valid_d = 1'b1;
        out_ir_d    = head_ir;
        out_pc_d    = pc_mem_q[rd_ptr_q];
        ctrl_d      = head_ctrl;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // state registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_pc_q    <= '0;
      ctrl_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_ir_q    <= out_ir_d;
      out_pc_q    <= out_pc_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_ir    = out_ir_q;
  assign out_pc    = out_pc_q;
  assign regWrite  = ctrl_q.reg_write;
  assign memWrite  = ctrl_q.mem_write;
  assign memRead   = ctrl_q.mem_read;
  assign alu_fun   = ctrl_q.alu_fun;
  assign alu_srcA  = ctrl_q.alu_src_a;
  assign alu_srcB  = ctrl_q.alu_src_b;
  assign rf_wr_sel = ctrl_q.rf_wr_sel;
  assign opcode    = ctrl_q.opcode;
  assign illegal   = ctrl_q.illegal;
  assign mul_en    = ctrl_q.mul_en;
  assign mul_op    = ctrl_q.mul_op;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table, hand-written
// corner sequences (backpressure fill, flush, mid-stream reset) and a random
// phase checked against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_ir, out_ir;
  logic [PC_W-1:0] in_pc, out_pc;
  logic in_ready, out_valid;
  logic regWrite, memWrite, memRead, alu_srcA, rf_wr_sel, illegal, mul_en;
  logic [3:0] alu_fun;
  logic [1:0] alu_srcB;
  logic [6:0] opcode;
  logic [2:0] mul_op;
  logic [2:0] count;
  logic [22:0] act_ctrl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .regWrite(regWrite), .memWrite(memWrite), .memRead(memRead), .alu_fun(alu_fun),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .rf_wr_sel(rf_wr_sel), .opcode(opcode),
    .illegal(illegal), .mul_en(mul_en), .mul_op(mul_op), .count(count)
  );

  assign act_ctrl = {regWrite, memWrite, memRead, alu_fun, alu_srcA, alu_srcB,
                     rf_wr_sel, opcode, illegal, mul_en, mul_op};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected bundle built from individual fields, same order as act_ctrl
  function automatic logic [22:0] pk(input logic [31:0] ir, input bit rw, mw, mr,
      input logic [3:0] af, input bit sa, input logic [1:0] sb, input bit ws, il, me,
      input logic [2:0] mo);
    return {rw, mw, mr, af, sa, sb, ws, ir[6:0], il, me, mo};
  endfunction

  // reference decoder written from the opcode rules
  function automatic logic [22:0] ref_decode(input logic [31:0] ir);
    logic [6:0] op;
    logic [2:0] f3;
    bit known, is_mul, rw, mw, mr, sa, ws, il, me;
    logic [3:0] af;
    logic [1:0] sb;
    logic [2:0] mo;
    op = ir[6:0];
    f3 = ir[14:12];
    known  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    is_mul = (op == 7'h33) && (ir[31:25] == 7'b0000001);
    rw = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) || (op == 7'h73 && f3 == 3'd1);
    mw = (op == 7'h23);
    mr = (op == 7'h03);
    ws = mr;
    sa = op inside {7'h17, 7'h6F, 7'h67, 7'h63};
    sb = (op inside {7'h6F, 7'h67}) ? 2'b10 : (op inside {7'h33, 7'h73}) ? 2'b01 : 2'b00;
    af = 4'b0000;
    if (op == 7'h37) af = 4'b1001;
    else if (op == 7'h13) af = {(f3 == 3'd5) && ir[30], f3};
    else if (op == 7'h33 && !is_mul) af = {(f3 == 3'd0 || f3 == 3'd5) && ir[30], f3};
    me = 0;
    mo = 3'b000;
    il = !known;
`ifdef DECODE_QUEUE_MEXT_EN
    if (is_mul) begin me = 1; mo = f3; end
`else
    if (is_mul) il = 1;
`endif
    if (il) begin
      rw = 0; mw = 0; mr = 0; sa = 0; ws = 0; af = '0; sb = '0; me = 0; mo = '0;
    end
    return {rw, mw, mr, af, sa, sb, ws, op, il, me, mo};
  endfunction

  // reference queue: FIFO contents plus the output slot
  logic [31:0] mq_ir[$];
  logic [31:0] mq_pc[$];
  bit          m_ov;
  logic [31:0] m_ir, m_pc;

  task automatic model_reset();
    mq_ir.delete();
    mq_pc.delete();
    m_ov = 0;
  endtask

  task automatic model_edge(input bit iv, input logic [31:0] ir, pc, input bit ordy, fl);
    bit do_pop, do_push;
    if (fl) begin
      model_reset();
    end else begin
      do_pop  = (mq_ir.size() > 0) && (!m_ov || ordy);
      do_push = iv && (mq_ir.size() < DEPTH);
      if (do_pop) begin
        m_ir = mq_ir.pop_front();
        m_pc = mq_pc.pop_front();
        m_ov = 1;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (do_push) begin
        mq_ir.push_back(ir);
        mq_pc.push_back(pc);
      end
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(mq_ir.size()));
    chk("in_ready", 32'(in_ready), 32'(mq_ir.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_ir", out_ir, m_ir);
      chk("out_pc", out_pc, m_pc);
      chk("ctrl", 32'(act_ctrl), 32'(ref_decode(m_ir)));
    end
  endtask

  // one clock: drive at negedge, model at posedge, check at next negedge
  task automatic cyc(input bit iv, input logic [31:0] ir, pc, input bit ordy, fl);
    in_valid = iv; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_edge(iv, ir, pc, ordy, fl);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [22:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

  initial begin
    logic [31:0] rir;
    //                 ir            rw mw mr  af     sa sb     ws il me mo
    vecs.push_back('{32'h00500093, pk(32'h00500093, 1, 0, 0, 4'b0000, 0, 2'b00, 0, 0, 0, 3'd0), "addi"});
    vecs.push_back('{32'h402080B3, pk(32'h402080B3, 1, 0, 0, 4'b1000, 0, 2'b01, 0, 0, 0, 3'd0), "sub"});
    vecs.push_back('{32'h4030D093, pk(32'h4030D093, 1, 0, 0, 4'b1101, 0, 2'b00, 0, 0, 0, 3'd0), "srai"});
    vecs.push_back('{32'h0020C0B3, pk(32'h0020C0B3, 1, 0, 0, 4'b0100, 0, 2'b01, 0, 0, 0, 3'd0), "xor"});
    vecs.push_back('{32'h123450B7, pk(32'h123450B7, 1, 0, 0, 4'b1001, 0, 2'b00, 0, 0, 0, 3'd0), "lui"});
    vecs.push_back('{32'h00000097, pk(32'h00000097, 1, 0, 0, 4'b0000, 1, 2'b00, 0, 0, 0, 3'd0), "auipc"});
    vecs.push_back('{32'h000000EF, pk(32'h000000EF, 1, 0, 0, 4'b0000, 1, 2'b10, 0, 0, 0, 3'd0), "jal"});
    vecs.push_back('{32'h000100E7, pk(32'h000100E7, 1, 0, 0, 4'b0000, 1, 2'b10, 0, 0, 0, 3'd0), "jalr"});
    vecs.push_back('{32'h00000063, pk(32'h00000063, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 0, 0, 3'd0), "beq"});
    vecs.push_back('{32'h00012083, pk(32'h00012083, 1, 0, 1, 4'b0000, 0, 2'b00, 1, 0, 0, 3'd0), "lw"});
    vecs.push_back('{32'h00112023, pk(32'h00112023, 0, 1, 0, 4'b0000, 0, 2'b00, 0, 0, 0, 3'd0), "sw"});
    vecs.push_back('{32'h300110F3, pk(32'h300110F3, 1, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 0, 3'd0), "csrrw"});
    vecs.push_back('{32'h00000073, pk(32'h00000073, 0, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 0, 3'd0), "ecall"});
    vecs.push_back('{32'h0000007F, pk(32'h0000007F, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1, 0, 3'd0), "bad_op"});
`ifdef DECODE_QUEUE_MEXT_EN
    vecs.push_back('{32'h022080B3, pk(32'h022080B3, 1, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 1, 3'd0), "mul"});
    vecs.push_back('{32'h0220B0B3, pk(32'h0220B0B3, 1, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 1, 3'd3), "mulhu"});
`else
    vecs.push_back('{32'h022080B3, pk(32'h022080B3, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1, 0, 3'd0), "mul"});
    vecs.push_back('{32'h0220B0B3, pk(32'h0220B0B3, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1, 0, 3'd0), "mulhu"});
`endif

    // reset state
    rst = 1; flush = 0; in_valid = 0; in_ir = '0; in_pc = '0; out_ready = 0;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ctrl", 32'(act_ctrl), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // decode table: push into empty queue, output appears two edges later
    foreach (vecs[i]) begin
      cyc(1, vecs[i].ir, 32'h1000 + 4 * i, 1, 0);
      chk({vecs[i].name, "_lat1"}, 32'(out_valid), 0);
      cyc(0, '0, '0, 1, 0);
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 1);
      chk(vecs[i].name, 32'(act_ctrl), 32'(vecs[i].exp));
      cyc(0, '0, '0, 1, 0);
    end

    // ordering: SUB then SRAI back to back
    cyc(1, 32'h402080B3, 32'h2000, 1, 0);
    cyc(1, 32'h4030D093, 32'h2004, 1, 0);
    chk("ord_sub", 32'(alu_fun), 32'b1000);
    chk("ord_sub_srcb", 32'(alu_srcB), 32'b01);
    cyc(0, '0, '0, 1, 0);
    chk("ord_srai", 32'(alu_fun), 32'b1101);
    chk("ord_srai_srcb", 32'(alu_srcB), 32'b00);
    cyc(0, '0, '0, 1, 0);

    // backpressure: 5 accepted (4 FIFO + output), then one pop
    for (int i = 0; i < 6; i++) cyc(1, 32'h00500093, 32'h100 + i, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_pc", out_pc, 32'h100);
    chk("full_stable_valid", 32'(out_valid), 1);
    cyc(1, 32'h00500093, 32'h200, 1, 0);
    chk("pop_in_ready", 32'(in_ready), 1);
    chk("pop_count", 32'(count), 3);
    chk("pop_out_pc", out_pc, 32'h101);
    for (int i = 0; i < 6; i++) cyc(0, '0, '0, 1, 0);

    // flush with 3 queued and a same-edge push
    for (int i = 0; i < 4; i++) cyc(1, 32'h0020C0B3, 32'h300 + i, 0, 0);
    chk("pre_flush_count", 32'(count), 3);
    cyc(1, 32'h00000097, 32'h3FF, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    cyc(0, '0, '0, 1, 0);
    chk("flush_drop_count", 32'(count), 0);
    chk("flush_drop_valid", 32'(out_valid), 0);

    // reset mid-stream with 2 entries queued
    for (int i = 0; i < 3; i++) cyc(1, 32'h00012083, 32'h400 + i, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    rst = 1;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ctrl", 32'(act_ctrl), 0);
    @(negedge clk);
    rst = 0;
    cyc(1, 32'h123450B7, 32'h777, 1, 0);
    cyc(0, '0, '0, 1, 0);
    chk("post_rst_first_pc", out_pc, 32'h777);
    chk("post_rst_first_ir", out_ir, 32'h123450B7);
    cyc(0, '0, '0, 1, 0);

    // random traffic against the reference queue
    for (int n = 0; n < 500; n++) begin
      rir = $urandom;
      if ($urandom_range(0, 3) != 0) rir[6:0] = ops[$urandom_range(0, 9)];
      if (rir[6:0] == 7'h33 && $urandom_range(0, 2) == 0) rir[31:25] = 7'b0000001;
      cyc($urandom_range(0, 1) == 1, rir, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 8; i++) cyc(0, '0, '0, 1, 0);
    chk("drain_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
